// File: rtl/gac_pkg.sv
// Shared definitions for the gac test-traffic generator: config register
// map, control-chain codes, generated-MD field offsets and FSM encoding.
package gac_pkg;

  // Config register addresses (carried in head beat bits [95:64])
  localparam logic [31:0] ADDR_START = 32'h6000_0000;
  localparam logic [31:0] ADDR_CNT   = 32'h6000_0001;
  localparam logic [31:0] ADDR_LEN   = 32'h6000_0002;
  localparam logic [31:0] ADDR_PROTO = 32'h6000_0003;
  localparam logic [31:0] ADDR_GAP   = 32'h6000_0004;

  // Control chain beat type in [133:132] and write opcode in [126:124]
  localparam logic [1:0] CHAIN_HEAD = 2'b01;
  localparam logic [1:0] CHAIN_TAIL = 2'b10;
  localparam logic [2:0] CFG_WR_OP  = 3'b010;

  // Generated MD field positions
  localparam int MD_DISCARD_BIT = 108;
  localparam int MD_LEN_LSB     = 96;
  localparam int MD_NMID_LSB    = 80;
  localparam int MD_PROTO_LSB   = 72;
  localparam int MD_TS_LSB      = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } gac_state_t;

  // Assemble one generated MD word; every bit not named here stays 0.
  function automatic logic [255:0] build_md(input logic [11:0] len,
                                            input logic [7:0]  nmid,
                                            input logic [7:0]  proto,
                                            input logic [31:0] ts);
    logic [255:0] md;
    md                        = '0;
    md[MD_LEN_LSB +: 12]      = len;
    md[MD_NMID_LSB +: 8]      = nmid;
    md[MD_PROTO_LSB +: 8]     = proto;
    md[MD_TS_LSB +: 32]       = ts;
    md[MD_DISCARD_BIT]        = 1'b0;
    return md;
  endfunction

endpackage

// File: rtl/gac_pkt_gen_if.sv
// MD/PHV output bus from the generator toward gme.
// Handshake: out_gac_md_wr / out_gac_phv_wr are single-cycle valid strobes,
// always asserted together, with no ready; the consumer must accept every
// strobed pair. in_gac_md_alf / in_gac_phv_alf are the only backpressure: the
// generator samples their OR in the cycle before it would emit and holds off
// while either is high, so a pair already strobed is never withdrawn.
interface gac_pkt_gen_if;
  logic [255:0]  out_gac_md;
  logic          out_gac_md_wr;
  logic          in_gac_md_alf;
  logic [1023:0] out_gac_phv;
  logic          out_gac_phv_wr;
  logic          in_gac_phv_alf;

  modport master (
    output out_gac_md, out_gac_md_wr, out_gac_phv, out_gac_phv_wr,
    input  in_gac_md_alf, in_gac_phv_alf
  );

  modport slave (
    input  out_gac_md, out_gac_md_wr, out_gac_phv, out_gac_phv_wr,
    output in_gac_md_alf, in_gac_phv_alf
  );
endinterface

// File: rtl/gac_cfg_regs.sv
// Control-chain front end: decodes config writes addressed to this module,
// drops those head/tail beats, forwards everything else one cycle later and
// holds the generator's config register file.
module gac_cfg_regs
  import gac_pkg::*;
#(
  parameter logic [7:0] GAC_MID = 8'd6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] cin_data_i,
  input  logic         cin_wr_i,
  output logic [133:0] cout_data_o,
  output logic         cout_wr_o,
  output logic [31:0]  cnt_o,
  output logic [11:0]  len_o,
  output logic [7:0]   proto_o,
  output logic [15:0]  gap_o,
  output logic         start_set_o,
  output logic         start_clr_o
);

  logic         start_q, start_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [11:0]  len_q, len_d;
  logic [7:0]   proto_q, proto_d;
  logic [15:0]  gap_q, gap_d;
  logic         drop_tail_q, drop_tail_d;
  logic [133:0] cout_data_q, cout_data_d;
  logic         cout_wr_q, cout_wr_d;
  logic         is_cfg_wr;
  logic [31:0]  cfg_addr;
  logic [31:0]  cfg_wdata;

  // Decode, register-file update, drop of consumed beats, forward path
  always_comb begin
    cfg_addr    = cin_data_i[95:64];
    cfg_wdata   = cin_data_i[31:0];
    is_cfg_wr   = cin_wr_i && (cin_data_i[133:132] == CHAIN_HEAD) &&
                  (cin_data_i[126:124] == CFG_WR_OP) && (cin_data_i[103:96] == GAC_MID);
    start_d     = start_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    proto_d     = proto_q;
    gap_d       = gap_q;
    drop_tail_d = drop_tail_q;
    if (is_cfg_wr) begin
      drop_tail_d = 1'b1;
      case (cfg_addr)
        ADDR_START: start_d = cfg_wdata[0];
        ADDR_CNT:   cnt_d   = cfg_wdata;
        ADDR_LEN:   len_d   = cfg_wdata[11:0];
        ADDR_PROTO: proto_d = cfg_wdata[7:0];
        ADDR_GAP:   gap_d   = cfg_wdata[15:0];
        default:    ;
      endcase
    end else if (cin_wr_i && drop_tail_q && (cin_data_i[133:132] == CHAIN_TAIL)) begin
      drop_tail_d = 1'b0;
    end
    // Consumed head and every beat up to its tail never reach cout
    cout_wr_d   = cin_wr_i && !is_cfg_wr && !drop_tail_q;
    cout_data_d = cin_data_i;
    // Start events only on a real 0->1 change; any 0 write is a stop
    start_set_o = is_cfg_wr && (cfg_addr == ADDR_START) && cfg_wdata[0] && !start_q;
    start_clr_o = is_cfg_wr && (cfg_addr == ADDR_START) && !cfg_wdata[0];
  end

  // Register file and forward-path registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      proto_q     <= '0;
      gap_q       <= '0;
      drop_tail_q <= 1'b0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
    end else begin
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      proto_q     <= proto_d;
      gap_q       <= gap_d;
      drop_tail_q <= drop_tail_d;
      cout_data_q <= cout_data_d;
      cout_wr_q   <= cout_wr_d;
    end
  end

  assign cout_data_o = cout_data_q;
  assign cout_wr_o   = cout_wr_q;
  assign cnt_o       = cnt_q;
  assign len_o       = len_q;
  assign proto_o     = proto_q;
  assign gap_o       = gap_q;

endmodule

// File: rtl/gac_pkt_gen.sv
// Test-traffic generator: emits a configured burst of MD/PHV pairs toward
// gme and brackets it with sent_start/sent_end levels for scm statistics.
module gac_pkt_gen
  import gac_pkg::*;
#(
  parameter             PLATFORM = "Xilinx",
  parameter logic [7:0] GAC_MID  = 8'd6,
  parameter logic [7:0] NMID     = 8'd7
) (
  input  logic          clk,
  input  logic          rst,
  gac_pkt_gen_if.master gme,
  output logic          gac2scm_sent_start,
  output logic          gac2scm_sent_end,
  input  logic [133:0]  cin_gac_data,
  input  logic          cin_gac_data_wr,
  output logic          cout_gac_ready,
  output logic [133:0]  cout_gac_data,
  output logic          cout_gac_data_wr,
  input  logic          cin_gac_ready,
  output gac_state_t    dbg_state_o
);

  // Vendor tag only; no vendor-specific logic exists
  if (PLATFORM != "Xilinx") begin : g_generic_platform
  end

  logic [31:0] cfg_cnt;
  logic [11:0] cfg_len;
  logic [7:0]  cfg_proto;
  logic [15:0] cfg_gap;
  logic        start_set, start_clr, alf;

  gac_state_t   state_q, state_d;
  logic [31:0]  seq_q, seq_d, sh_cnt_q, sh_cnt_d, ts_q, phv_seq_q, phv_seq_d;
  logic [11:0]  sh_len_q, sh_len_d;
  logic [7:0]   sh_proto_q, sh_proto_d;
  logic [15:0]  sh_gap_q, sh_gap_d, gap_cnt_q, gap_cnt_d;
  logic [255:0] md_q, md_d;
  logic         wr_q, wr_d, ss_q, ss_d, se_q, se_d;

  gac_cfg_regs #(.GAC_MID(GAC_MID)) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cin_data_i  (cin_gac_data),
    .cin_wr_i    (cin_gac_data_wr),
    .cout_data_o (cout_gac_data),
    .cout_wr_o   (cout_gac_data_wr),
    .cnt_o       (cfg_cnt),
    .len_o       (cfg_len),
    .proto_o     (cfg_proto),
    .gap_o       (cfg_gap),
    .start_set_o (start_set),
    .start_clr_o (start_clr)
  );

  assign cout_gac_ready = cin_gac_ready;
  assign alf            = gme.in_gac_md_alf | gme.in_gac_phv_alf;

  // Free-running timestamp stamped into each emitted MD
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end

  // Burst FSM next-state, emit decision and bracket levels
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    gap_cnt_d  = gap_cnt_q;
    sh_cnt_d   = sh_cnt_q;
    sh_len_d   = sh_len_q;
    sh_proto_d = sh_proto_q;
    sh_gap_d   = sh_gap_q;
    md_d       = md_q;
    phv_seq_d  = phv_seq_q;
    wr_d       = 1'b0;
    ss_d       = ss_q;
    se_d       = se_q;
    case (state_q)
      ST_IDLE: begin
        if (start_set) begin
          sh_cnt_d   = cfg_cnt;
          sh_len_d   = cfg_len;
          sh_proto_d = cfg_proto;
          sh_gap_d   = cfg_gap;
          seq_d      = '0;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (start_clr) begin
          state_d = ST_IDLE;
        end else begin
          ss_d    = 1'b1;
          state_d = (sh_cnt_q == 32'd0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (start_clr) begin
          ss_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (!alf) begin
          wr_d      = 1'b1;
          md_d      = build_md(sh_len_q, NMID, sh_proto_q, ts_q);
          phv_seq_d = seq_q;
          seq_d     = seq_q + 32'd1;
          if (seq_q + 32'd1 == sh_cnt_q) begin
            state_d = ST_DONE;
          end else if (sh_gap_q != 16'd0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (start_clr) begin
          ss_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (gap_cnt_q == sh_gap_q - 16'd1) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        se_d = 1'b1;
        if (start_clr) begin
          ss_d    = 1'b0;
          se_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      gap_cnt_q  <= '0;
      sh_cnt_q   <= '0;
      sh_len_q   <= '0;
      sh_proto_q <= '0;
      sh_gap_q   <= '0;
      md_q       <= '0;
      phv_seq_q  <= '0;
      wr_q       <= 1'b0;
      ss_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      gap_cnt_q  <= gap_cnt_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_len_q   <= sh_len_d;
      sh_proto_q <= sh_proto_d;
      sh_gap_q   <= sh_gap_d;
      md_q       <= md_d;
      phv_seq_q  <= phv_seq_d;
      wr_q       <= wr_d;
      ss_q       <= ss_d;
      se_q       <= se_d;
    end
  end

  assign gme.out_gac_md      = md_q;
  assign gme.out_gac_md_wr   = wr_q;
  assign gme.out_gac_phv     = {992'd0, phv_seq_q};
  assign gme.out_gac_phv_wr  = wr_q;
  assign gac2scm_sent_start  = ss_q;
  assign gac2scm_sent_end    = se_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_gac_pkt_gen.sv
// Bench for gac_pkt_gen: chain pass-through, bursts, backpressure, gap,
// zero count, abort and reset mid-burst.
module tb_gac_pkt_gen;
  import gac_pkg::*;

  localparam int W = 60;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gac_pkt_gen_if gme();
  logic [133:0] cin_data, cout_data;
  logic         cin_wr, cin_ready, cout_ready, cout_wr;
  logic         sent_start, sent_end;
  gac_state_t   dbg_state;

  gac_pkt_gen #(.PLATFORM("Xilinx"), .GAC_MID(8'd6), .NMID(8'd7)) dut (
    .clk                (clk),
    .rst                (rst),
    .gme                (gme),
    .gac2scm_sent_start (sent_start),
    .gac2scm_sent_end   (sent_end),
    .cin_gac_data       (cin_data),
    .cin_gac_data_wr    (cin_wr),
    .cout_gac_ready     (cout_ready),
    .cout_gac_data      (cout_data),
    .cout_gac_data_wr   (cout_wr),
    .cin_gac_ready      (cin_ready),
    .dbg_state_o        (dbg_state)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int    assert_cnt = 0;
  int    fail_cnt   = 0;
  int    pair_cnt   = 0;
  int    mon_cyc    = 0;
  int    last_cyc   = 0;
  int    se_rise_cyc = 0;
  int    se_cycles  = 0;
  int    alf_viol   = 0;
  int    burst_id   = 0;
  int    seen_burst = 0;
  int    exp_delta  = 0;
  logic  alf_prev   = 1'b0;
  logic  se_prev    = 1'b0;
  logic  ss_e0, ss_e1;
  logic [31:0] tb_ts;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference cycle counter for MD timestamps
  always @(posedge clk) begin
    if (rst) tb_ts <= 32'd0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  // Output monitor: pops expected pairs and checks timing properties
  always @(negedge clk) begin
    if (rst) begin
      alf_prev = 1'b0;
      se_prev  = 1'b0;
    end else begin
      mon_cyc++;
      if (gme.out_gac_md_wr || gme.out_gac_phv_wr) begin
        check("phv_wr_eq_md_wr", gme.out_gac_phv_wr, gme.out_gac_md_wr);
        check("pair_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          check("pair_fields", {gme.out_gac_md[107:96], gme.out_gac_md[87:80],
                                gme.out_gac_md[79:72], gme.out_gac_phv[31:0]}, exp_q.pop_front());
        check("md_other_bits", {gme.out_gac_md[255:108], gme.out_gac_md[95:88],
                                gme.out_gac_md[71:32]}, 0);
        check("phv_upper_bits", gme.out_gac_phv[1023:32], 0);
        check("md_ts", gme.out_gac_md[31:0], tb_ts - 32'd1);
        if (seen_burst == burst_id && exp_delta != 0)
          check("pulse_spacing", mon_cyc - last_cyc, exp_delta);
        if (alf_prev) alf_viol++;
        seen_burst = burst_id;
        last_cyc   = mon_cyc;
        pair_cnt++;
      end
      if (sent_end && !se_prev) se_rise_cyc = mon_cyc;
      if (sent_end) se_cycles++;
      se_prev  = sent_end;
      alf_prev = gme.in_gac_md_alf | gme.in_gac_phv_alf;
    end
  end

  // Driver tasks
  task automatic chain_beat(input logic [133:0] d);
    @(posedge clk); #1;
    cin_data = d;
    cin_wr   = 1'b1;
  endtask

  task automatic chain_idle();
    @(posedge clk); #1;
    cin_data = '0;
    cin_wr   = 1'b0;
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] h, t;
    h = '0; h[133:132] = 2'b01; h[126:124] = 3'b010; h[103:96] = 8'd6;
    h[95:64] = addr; h[31:0] = data;
    t = '0; t[133:132] = 2'b10; t[15:0] = 16'h5a5a;
    chain_beat(h);
    chain_beat(t);
    @(negedge clk); ss_e0 = sent_start;
    check("cfg_head_dropped", cout_wr, 1'b0);
    chain_idle();
    @(negedge clk); ss_e1 = sent_start;
    check("cfg_tail_dropped", cout_wr, 1'b0);
  endtask

  task automatic start_burst(input logic [31:0] cnt, input logic [11:0] len,
                             input logic [7:0] proto, input logic [15:0] gap, input int delta);
    cfg_write(32'h6000_0001, cnt);
    cfg_write(32'h6000_0002, {20'd0, len});
    cfg_write(32'h6000_0003, {24'd0, proto});
    cfg_write(32'h6000_0004, {16'd0, gap});
    exp_delta = delta;
    burst_id++;
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back({len, 8'd7, proto, 32'(i)});
    cfg_write(32'h6000_0000, 32'd1);
  endtask

  task automatic stop_burst();
    cfg_write(32'h6000_0000, 32'd0);
    check("stop_sent_start", sent_start, 1'b0);
    check("stop_sent_end", sent_end, 1'b0);
    check("stop_state", dbg_state, ST_IDLE);
  endtask

  task automatic wait_pairs(input int n, input string tag);
    int b = 0;
    while (pair_cnt < n && b < 500) begin
      @(negedge clk); #1;
      b++;
    end
    check(tag, pair_cnt >= n, 1'b1);
  endtask

  task automatic wait_end(input string tag);
    int b = 0;
    while (!sent_end && b < 500) begin
      @(negedge clk); #1;
      b++;
    end
    check(tag, sent_end, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_md_wr"}, gme.out_gac_md_wr, 1'b0);
    check({tag, "_phv_wr"}, gme.out_gac_phv_wr, 1'b0);
    check({tag, "_md"}, gme.out_gac_md, 0);
    check({tag, "_phv"}, gme.out_gac_phv[255:0], 0);
    check({tag, "_sent_start"}, sent_start, 1'b0);
    check({tag, "_sent_end"}, sent_end, 1'b0);
    check({tag, "_cout_wr"}, cout_wr, 1'b0);
    check({tag, "_cout_data"}, cout_data, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Watchdog
  initial begin
    #300000;
    fail_cnt++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  // Stimulus sequence
  initial begin
    logic [133:0] h, t;
    int base, se_base, pc;
    rst = 1'b1; cin_data = '0; cin_wr = 1'b0; cin_ready = 1'b0;
    gme.in_gac_md_alf = 1'b0; gme.in_gac_phv_alf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    cin_ready = 1'b1; #1;
    check("ready_passthrough", cout_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;

    // Pass-through of another module's control write
    h = '0; h[133:132] = 2'b01; h[126:124] = 3'b010; h[103:96] = 8'd3;
    h[95:64] = 32'h6000_0000; h[31:0] = 32'd1;
    t = '0; t[133:132] = 2'b10; t[15:0] = 16'hbeef;
    chain_beat(h);
    chain_beat(t);
    @(negedge clk);
    check("pt_head_wr", cout_wr, 1'b1);
    check("pt_head_data", cout_data, h);
    chain_idle();
    @(negedge clk);
    check("pt_tail_wr", cout_wr, 1'b1);
    check("pt_tail_data", cout_data, t);
    @(negedge clk);
    check("pt_idle_wr", cout_wr, 1'b0);
    check("pt_no_start", sent_start, 1'b0);
    check("pt_state", dbg_state, ST_IDLE);

    // Back-to-back burst of 4
    base = pair_cnt;
    start_burst(32'd4, 12'd64, 8'd1, 16'd0, 1);
    check("burst_ss_before", ss_e0, 1'b0);
    check("burst_ss_rise", ss_e1, 1'b1);
    wait_end("burst_end_seen");
    check("burst_pairs", pair_cnt - base, 4);
    check("burst_end_after_last", se_rise_cyc > last_cyc, 1'b1);
    check("burst_queue_empty", exp_q.size(), 0);
    stop_burst();

    // Backpressure mid-burst
    base = pair_cnt;
    start_burst(32'd3, 12'd128, 8'd2, 16'd0, 0);
    wait_pairs(base + 1, "bp_first_pair");
    @(posedge clk); #1 gme.in_gac_phv_alf = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp_held_pairs", pair_cnt - base, 2);
    gme.in_gac_phv_alf = 1'b0;
    wait_end("bp_end_seen");
    check("bp_pairs", pair_cnt - base, 3);
    check("bp_alf_violations", alf_viol, 0);
    check("bp_queue_empty", exp_q.size(), 0);
    stop_burst();

    // Inter-packet gap of 5 idle cycles
    base = pair_cnt;
    start_burst(32'd3, 12'd32, 8'd3, 16'd5, 6);
    wait_end("gap_end_seen");
    check("gap_pairs", pair_cnt - base, 3);
    check("gap_queue_empty", exp_q.size(), 0);
    stop_burst();

    // Zero-length burst
    base = pair_cnt;
    start_burst(32'd0, 12'd16, 8'd4, 16'd0, 0);
    check("zero_ss_rise", ss_e1, 1'b1);
    wait_end("zero_end_seen");
    check("zero_sent_start", sent_start, 1'b1);
    check("zero_pairs", pair_cnt - base, 0);
    stop_burst();

    // Abort after the second of ten pairs
    base = pair_cnt;
    se_base = se_cycles;
    start_burst(32'd10, 12'd64, 8'd5, 16'd0, 1);
    wait_pairs(base + 2, "abort_two_pairs");
    cfg_write(32'h6000_0000, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_at_most_3", (pair_cnt - base) <= 3, 1'b1);
    check("abort_no_end", se_cycles - se_base, 0);
    check("abort_sent_start", sent_start, 1'b0);
    check("abort_state", dbg_state, ST_IDLE);
    exp_q.delete();

    // Reset in the middle of a burst
    base = pair_cnt;
    start_burst(32'd10, 12'd64, 8'd6, 16'd0, 1);
    wait_pairs(base + 2, "rst_two_pairs");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    pc = pair_cnt;
    repeat (6) @(negedge clk);
    check("post_rst_no_pairs", pair_cnt - pc, 0);
    check("post_rst_state", dbg_state, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
